dec_sweep_onehot: RTL and testbench
===================================

Name: dec_sweep_onehot

Overview:
- Parametrised, registered N-to-M one-hot decoder with enable; successor to the fixed 3-to-8 gate-level decoder.
- Drives register-file write-enables (and similar one-hot selects) in the CPU datapath.
- Adds a registered output stage, out-of-range detection for non-power-of-two M, and a self-timed sweep mode.
- Sweep mode asserts every output once, in order, so a register file can be cleared after reset.

Parameters:
- SEL_W, 3: width of select input `in`.
- OUT_W, 8: number of one-hot outputs. Legal range is 2 to 2**SEL_W. Elaboration fails outside that range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  SEL_W  select index, normal mode.
- enable  in  1  decode request, normal mode.
- sweep_start  in  1  request a full sweep; sampled only in IDLE.
- out  out  OUT_W  registered one-hot (or all-zero) select.
- out_of_range  out  1  registered flag: previous cycle's enabled request had in >= OUT_W.
- sweep_busy  out  1  high while the sweep is driving out.
- sweep_done  out  1  one-cycle pulse after the last sweep output.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, out_of_range=0, sweep_busy=0, sweep_done=0.
  - state=IDLE, sweep index=0.
  - Effective immediately, with no clock needed. Applies mid-sweep too: the sweep aborts and there is no sweep_done pulse.
- State machine: IDLE, SWEEP, DONE.
- IDLE, normal decode (1-cycle latency):
  - At each rising edge, if enable=1 and in < OUT_W: out <= one-hot(in) (bit `in` set only), out_of_range <= 0.
  - If enable=1 and in >= OUT_W: out <= 0, out_of_range <= 1.
  - If enable=0: out <= 0, out_of_range <= 0.
  - out is never multi-hot in any state.
- IDLE -> SWEEP:
  - Sampled at the edge where sweep_start=1. Call this edge E0.
  - At E0: out <= one-hot(0), sweep_busy <= 1, index <= 1, out_of_range <= 0.
  - sweep_start has priority over enable in the same cycle. That enable request is dropped and does not set out_of_range.
- SWEEP:
  - At each edge Ek (k=1..OUT_W-1): out <= one-hot(k), index increments.
  - At E(OUT_W): out <= 0, sweep_busy <= 0, sweep_done <= 1, state <= DONE.
  - Sweep visits indices 0..OUT_W-1 only; out-of-range indices are skipped.
  - enable, in and sweep_start are ignored; out_of_range stays 0.
- DONE:
  - Lasts one cycle; inputs ignored.
  - Next edge: sweep_done <= 0, state <= IDLE.
  - Next decode or sweep can be accepted at the edge after that.
- Sweep timing:
  - Total: OUT_W cycles busy plus 1 cycle done.
  - sweep_start held high after DONE starts a new sweep as soon as IDLE samples it.
- Index counter:
  - Width is SEL_W+1 so it reaches OUT_W without wrap when OUT_W = 2**SEL_W.
  - It is not an outside-visible wrap point.
- Derived check: sweep_busy == (state==SWEEP). sweep_done == (state==DONE).

Test Plan:
- SEL_W=3, OUT_W=8; reset low, then high; enable=1, in=5 for one edge -> next cycle out=8'b0010_0000, out_of_range=0. Then enable=0 -> out=0 after the following edge.
- SEL_W=3, OUT_W=6; enable=1, in=7 -> out=6'b000000, out_of_range=1 for one cycle. Then in=5 -> out=6'b100000, out_of_range=0.
- OUT_W=8; pulse sweep_start at E0 -> out=0x01,0x02,...,0x80 on consecutive cycles with sweep_busy=1. Then out=0, sweep_done=1 for exactly 1 cycle. IDLE on the cycle after; 9 cycles total.
- During SWEEP, drive enable=1, in=3 and sweep_start=1 every cycle -> sweep sequence unchanged, out_of_range stays 0. With sweep_start still high after DONE, a second sweep begins as soon as IDLE samples it.
- sweep_start=1 and enable=1, in=2 in the same IDLE cycle -> out=one-hot(0), not one-hot(2).
- Assert reset (low) asynchronously while out=0x08 mid-sweep -> out, sweep_busy, sweep_done all 0 immediately. After release, enable=1, in=1 -> out=0x02 next cycle; no sweep_done pulse.

Source files
------------

// File: rtl/dec_sweep_onehot_if.sv
// Select/decode bundle for dec_sweep_onehot: request side from the master,
// registered one-hot select and sweep status back from the slave.
interface dec_sweep_onehot_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_W = 8
);
    logic [SEL_W-1:0] in;
    logic             enable;
    logic             sweep_start;
    logic [OUT_W-1:0] out;
    logic             out_of_range;
    logic             sweep_busy;
    logic             sweep_done;

    modport master (
        output in,
        output enable,
        output sweep_start,
        input  out,
        input  out_of_range,
        input  sweep_busy,
        input  sweep_done
    );

    modport slave (
        input  in,
        input  enable,
        input  sweep_start,
        output out,
        output out_of_range,
        output sweep_busy,
        output sweep_done
    );
endinterface

// File: rtl/dec_sweep_onehot.sv
// Registered N-to-M one-hot decoder with out-of-range flag and a self-timed
// sweep that asserts every output once, in order (register-file clear).
module dec_sweep_onehot #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_W = 8
) (
    input logic              clk,
    input logic              reset,
    dec_sweep_onehot_if.slave bus
);
    // One extra bit so the index can reach OUT_W when OUT_W == 2**SEL_W.
    localparam int unsigned IdxW = SEL_W + 1;

    if (OUT_W < 2 || OUT_W > (1 << SEL_W)) begin : g_bad_out_w
        $error("dec_sweep_onehot: OUT_W must lie in 2 .. 2**SEL_W");
    end

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [OUT_W-1:0] out_q;
    logic             oor_q;
    logic             busy_q;
    logic             done_q;
    logic             in_range;

    assign in_range = IdxW'(bus.in) < IdxW'(OUT_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            out_q   <= '0;
            oor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A sweep request wins over a same-cycle decode request.
                    if (bus.sweep_start) begin
                        out_q   <= OUT_W'(1);
                        oor_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        idx_q   <= IdxW'(1);
                        state_q <= StSweep;
                    end else if (bus.enable && in_range) begin
                        out_q <= OUT_W'(1) << bus.in;
                        oor_q <= 1'b0;
                    end else begin
                        out_q <= '0;
                        oor_q <= bus.enable;
                    end
                end
                StSweep: begin
                    if (idx_q == IdxW'(OUT_W)) begin
                        out_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        out_q <= OUT_W'(1) << idx_q;
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    out_q   <= '0;
                    oor_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out          = out_q;
    assign bus.out_of_range = oor_q;
    assign bus.sweep_busy   = busy_q;
    assign bus.sweep_done   = done_q;
endmodule

// File: tb/tb_dec_sweep_onehot.sv
// Bench for dec_sweep_onehot: an 8-output and a 6-output instance driven in
// lockstep, checked against constant tables, hand sequences and a sweep model.
module tb_dec_sweep_onehot;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dec_sweep_onehot_if #(.SEL_W(3), .OUT_W(8)) ifa ();
    dec_sweep_onehot_if #(.SEL_W(3), .OUT_W(6)) ifb ();

    dec_sweep_onehot #(.SEL_W(3), .OUT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    dec_sweep_onehot #(.SEL_W(3), .OUT_W(6)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct packed {
        logic [7:0] out;
        logic       oor;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic [7:0] want_a;
        logic       oor_a;
        logic [5:0] want_b;
        logic       oor_b;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: per instance, -1 when idle, else how many edges into the sweep.
    int   pos[2];
    obs_t expv[2];

    function automatic int ow_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic obs_t act(input int d);
        if (d == 0) return {ifa.out, ifa.out_of_range, ifa.sweep_busy, ifa.sweep_done};
        return {2'b00, ifb.out, ifb.out_of_range, ifb.sweep_busy, ifb.sweep_done};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got out=%h oor=%b busy=%b done=%b, want out=%h oor=%b busy=%b done=%b",
                     name, got.out, got.oor, got.busy, got.done,
                     want.out, want.oor, want.busy, want.done);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d]  = -1;
            expv[d] = '0;
        end
    endtask

    task automatic model_edge(input logic [2:0] sel, input logic en, input logic ss);
        for (int d = 0; d < 2; d++) begin
            int ow;
            ow = ow_of(d);
            if (pos[d] >= 0) begin
                pos[d]++;
                if (pos[d] > ow) begin
                    pos[d]  = -1;
                    expv[d] = '0;
                end else if (pos[d] == ow) begin
                    expv[d] = {8'h00, 1'b0, 1'b0, 1'b1};
                end else begin
                    expv[d] = {8'd1 << pos[d], 1'b0, 1'b1, 1'b0};
                end
            end else if (ss) begin
                pos[d]  = 0;
                expv[d] = {8'h01, 1'b0, 1'b1, 1'b0};
            end else if (en) begin
                if (int'(sel) < ow) expv[d] = {8'd1 << sel, 1'b0, 1'b0, 1'b0};
                else                expv[d] = {8'h00, 1'b1, 1'b0, 1'b0};
            end else begin
                expv[d] = '0;
            end
        end
    endtask

    // Called at a falling edge; applies inputs across one rising edge.
    task automatic step(input logic [2:0] sel, input logic en, input logic ss, input string tag);
        ifa.in = sel; ifa.enable = en; ifa.sweep_start = ss;
        ifb.in = sel; ifb.enable = en; ifb.sweep_start = ss;
        @(posedge clk);
        model_edge(sel, en, ss);
        @(negedge clk);
        check({tag, "/model_a"}, act(0), expv[0]);
        check({tag, "/model_b"}, act(1), expv[1]);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd5, 1'b1, 8'h20, 1'b0, 6'h20, 1'b0};
        vecs[1] = '{3'd5, 1'b0, 8'h00, 1'b0, 6'h00, 1'b0};
        vecs[2] = '{3'd7, 1'b1, 8'h80, 1'b0, 6'h00, 1'b1};
        vecs[3] = '{3'd5, 1'b1, 8'h20, 1'b0, 6'h20, 1'b0};
        vecs[4] = '{3'd6, 1'b1, 8'h40, 1'b0, 6'h00, 1'b1};
        vecs[5] = '{3'd0, 1'b1, 8'h01, 1'b0, 6'h01, 1'b0};
        vecs[6] = '{3'd7, 1'b0, 8'h00, 1'b0, 6'h00, 1'b0};
        vecs[7] = '{3'd3, 1'b1, 8'h08, 1'b0, 6'h08, 1'b0};

        ifa.in = '0; ifa.enable = 1'b0; ifa.sweep_start = 1'b0;
        ifb.in = '0; ifb.enable = 1'b0; ifb.sweep_start = 1'b0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_a", act(0), '0);
        check("reset_b", act(1), '0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].sel, vecs[i].en, 1'b0, "vec");
            check("tbl_a", act(0), {vecs[i].want_a, vecs[i].oor_a, 1'b0, 1'b0});
            check("tbl_b", act(1), {2'b00, vecs[i].want_b, vecs[i].oor_b, 1'b0, 1'b0});
        end

        // Plain sweep on the 8-output instance: 8 busy cycles, 1 done, then idle.
        step(3'd0, 1'b0, 1'b1, "sw1");
        check("sw1_e0", act(0), {8'h01, 1'b0, 1'b1, 1'b0});
        for (int k = 1; k < 8; k++) begin
            step(3'd0, 1'b0, 1'b0, "sw1");
            check("sw1_ek", act(0), {8'd1 << k, 1'b0, 1'b1, 1'b0});
        end
        step(3'd0, 1'b0, 1'b0, "sw1");
        check("sw1_done", act(0), {8'h00, 1'b0, 1'b0, 1'b1});
        step(3'd0, 1'b0, 1'b0, "sw1");
        check("sw1_idle", act(0), '0);

        // Noisy inputs held through a sweep; held start relaunches after DONE.
        for (int i = 0; i <= 10; i++) begin
            obs_t w;
            step(3'd3, 1'b1, 1'b1, "sw2");
            if (i < 8)       w = {8'd1 << i, 1'b0, 1'b1, 1'b0};
            else if (i == 8) w = {8'h00, 1'b0, 1'b0, 1'b1};
            else if (i == 9) w = '0;
            else             w = {8'h01, 1'b0, 1'b1, 1'b0};
            check("sw2_a", act(0), w);
        end
        for (int i = 0; i < 9; i++) step(3'd0, 1'b0, 1'b0, "sw2_tail");
        check("sw2_end", act(0), '0);

        // Asynchronous reset mid-sweep, between clock edges.
        step(3'd0, 1'b0, 1'b1, "sw3");
        for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b0, "sw3");
        check("sw3_mid", act(0), {8'h08, 1'b0, 1'b1, 1'b0});
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_a", act(0), '0);
        check("arst_b", act(1), '0);
        @(posedge clk);
        @(negedge clk);
        check("arst_hold", act(0), '0);
        reset = 1'b1;
        step(3'd1, 1'b1, 1'b0, "post_rst");
        check("post_rst_a", act(0), {8'h02, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) step(3'd0, 1'b0, 1'b0, "post_rst_quiet");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] sel;
            logic       en;
            logic       ss;
            sel = 3'($urandom_range(7));
            en  = 1'($urandom_range(1));
            ss  = ($urandom_range(15) == 0);
            step(sel, en, ss, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
